fp_muldiv_unit: RTL and testbench
=================================

// Module: fp_muldiv_unit
// PURPOSE
//  Parametrised IEEE-754 floating-point multiply/divide execution unit for the
//  out-of-order core. It sits between the reservation station and the CDB/ROB
//  writeback. It accepts one operation through a valid/ready handshake,
//  computes it over several cycles, and returns the result with its ROB and
//  destination tags. The unit is not pipelined: one operation is in flight.
// PARAMETERS
//  TAG_W  5   width of ROB tag and destination (save) tag
//  EXP_W  8   exponent width (8 = binary32, 11 = binary64)
//  MAN_W  23  stored mantissa width (23 = binary32, 52 = binary64)
//  Derived: FW = 1+EXP_W+MAN_W (operand width); DIV_IT = MAN_W+3 quotient bits
// PORTS
//  clk       in   1       clock; all logic on posedge
//  rst       in   1       synchronous reset, active-low
//  in_valid  in   1       operation offered
//  in_ready  out  1       unit can accept (state IDLE)
//  ctrl      in   4       4'b0010 = MUL, 4'b0011 = DIV; other codes are illegal (see below)
//  d         in   FW      operand A (dividend for DIV)
//  e         in   FW      operand B (divisor for DIV)
//  rob_in    in   TAG_W   ROB tag, returned unchanged
//  save_in   in   TAG_W   destination tag, returned unchanged
//  out_valid out  1       result valid
//  out_ready in   1       consumer accepts result
//  f         out  FW      result
//  rob_out   out  TAG_W   tag of the result
//  save_out  out  TAG_W   destination tag of the result
//  flags     out  5       {NV, DZ, OF, UF, NX}
// BEHAVIOUR
//  Reset (rst==0 at posedge): state=IDLE, in_ready=0 during reset, out_valid=0,
//   f/rob_out/save_out/flags=0. The unit abandons any in-flight op with no output.
//  Accept: when in_valid && in_ready, the unit latches operands, ctrl and tags
//   at cycle T, and in_ready drops to 0 at T+1.
//  FSM: IDLE -> UNPACK -> (MUL | DIV_IT x DIV_IT cycles | SPECIAL) -> ROUND -> DONE.
//   DONE -> IDLE when out_ready=1 at a posedge with out_valid=1.
//  Latency, accept to first out_valid cycle:
//   - MUL: 3 cycles.
//   - DIV: DIV_IT+3 cycles (29 for binary32).
//   - SPECIAL: 2 cycles; ROUND is skipped.
//  SPECIAL covers any NaN, inf or zero operand, and divide-by-zero.
//  Backpressure: f, rob_out, save_out and flags hold stable while
//   out_valid && !out_ready. in_ready=0 until the unit returns to IDLE.
//   Back-to-back: a new op can be accepted the cycle after DONE is consumed.
//  Arithmetic:
//   - MUL uses a (MAN_W+1)x(MAN_W+1) significand product.
//   - DIV is restoring radix-2, one quotient bit per cycle, remainder as sticky.
//   - Exponent uses EXP_W+2 signed bits; bias = 2^(EXP_W-1)-1.
//   - Rounding is round-to-nearest-even only.
//   - Subnormal inputs are treated as zero; subnormal results flush to signed
//     zero with UF|NX.
//   - Overflow gives signed inf with OF|NX.
//  Specials (result -> flags):
//   - any NaN operand -> canonical qNaN (exp all 1, MSB of mantissa 1, sign 0) -> NV only if an operand is sNaN
//   - 0*inf or inf/inf or 0/0 -> qNaN -> NV
//   - x/0 with x finite nonzero -> signed inf -> DZ
//   - result sign is always sign(d)^sign(e), except for NaN results
//  Illegal ctrl: the op is accepted and completes on the SPECIAL path with
//   f=qNaN and NV=1; the unit never hangs.
//  in_valid while busy is ignored (no accept); the source holds it.
// CONFIGURATION
//  Macro FP_MULDIV_FLUSH_EN:
//   - Defined: adds input port flush (1 bit) and flush_tag (TAG_W). At a posedge
//     with flush=1, an in-flight op (UNPACK..DONE) is squashed if
//     rob_out-age >= flush_tag (tag compare: equal or younger, modulo 2^TAG_W).
//     The unit goes to IDLE next cycle with out_valid=0 and no result emitted.
//     Flush in IDLE has no effect. Flush wins over a same-cycle out_ready handshake.
//   - Not defined: the ports are absent and ops always complete.
// TESTING
//  1 DIV d=c396d200 e=c0100000 ctrl=0011 rob_in=3 save_in=3 -> f=43061000 rob_out=3 save_out=3 flags=0 at T+29
//  2 MUL d=40ae0000 e=bec00000 ctrl=0010 -> f=c0028000 flags=0 at T+3; hold out_ready=0 5 cycles -> f stable, in_ready=0
//  3 DIV d=3f800000 e=00000000 -> f=7f800000 flags=DZ at T+2; MUL d=00000000 e=7f800000 -> f=7fc00000 NV
//  4 MUL d=7f000000 e=7f000000 -> f=7f800000 OF|NX; MUL d=00800000 e=00800000 -> f=00000000 UF|NX
//  5 rst=0 at T+10 of a DIV -> out_valid=0 and never asserts; next op after reset gives a correct result
//  6 (FLUSH_EN) DIV rob_in=7, flush=1 flush_tag=5 at T+12 -> no out_valid; flush_tag=9 -> result emitted normally

Source files
------------

// File: rtl/fp_muldiv_unit.sv
// Non-pipelined IEEE-754 multiply/divide unit with RNE rounding and tag passthrough.
// Optional squash port pair (flush, flush_tag) enabled by macro FP_MULDIV_FLUSH_EN.
module fp_muldiv_unit #(
   parameter int TAG_W = 5,
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic                 clk,
   input  logic                 rst,
`ifdef FP_MULDIV_FLUSH_EN
   input  logic                 flush,
   input  logic [TAG_W-1:0]     flush_tag,
`endif
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [3:0]           ctrl,
   input  logic [EXP_W+MAN_W:0] d,
   input  logic [EXP_W+MAN_W:0] e,
   input  logic [TAG_W-1:0]     rob_in,
   input  logic [TAG_W-1:0]     save_in,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [EXP_W+MAN_W:0] f,
   output logic [TAG_W-1:0]     rob_out,
   output logic [TAG_W-1:0]     save_out,
   output logic [4:0]           flags
);
   localparam int FW     = 1 + EXP_W + MAN_W;
   localparam int DIV_IT = MAN_W + 3;
   localparam int SW     = 2 * (MAN_W + 1);
   localparam int EW     = EXP_W + 2;
   localparam int CW     = $clog2(DIV_IT + 1);
   localparam int BIAS   = (1 << (EXP_W - 1)) - 1;
   localparam logic signed [EW-1:0] EMAX = EW'((1 << EXP_W) - 1);
   localparam logic [3:0] OP_MUL = 4'b0010;
   localparam logic [3:0] OP_DIV = 4'b0011;
   localparam logic [FW-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

   typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_MUL, S_DIV, S_SPECIAL, S_ROUND, S_DONE} state_t;
   state_t state, state_n;

   // Handshake: a transfer happens on a posedge where valid and ready are both high;
   // the producer holds valid and payload until that edge, ready never depends on valid.
   logic [FW-1:0]          op_a, op_b;
   logic [3:0]             op_ctrl;
   logic [MAN_W:0]         ma, mb;
   logic [MAN_W+1:0]       rem;
   logic [DIV_IT-1:0]      quo;
   logic [CW-1:0]          cnt;
   logic [SW-1:0]          sig;
   logic signed [EW-1:0]   exp_q;

   logic [EXP_W-1:0] ea, eb;
   logic [MAN_W-1:0] fa, fb;
   logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan;
   logic is_mul, is_div, sgn, special, accept, squash;
   logic [FW-1:0] spec_f, rnd_f;
   logic [4:0]    spec_flags, rnd_flags;

   assign ea     = op_a[FW-2:MAN_W];
   assign eb     = op_b[FW-2:MAN_W];
   assign fa     = op_a[MAN_W-1:0];
   assign fb     = op_b[MAN_W-1:0];
   assign a_zero = (ea == '0);
   assign b_zero = (eb == '0);
   assign a_inf  = (&ea) && (fa == '0);
   assign b_inf  = (&eb) && (fb == '0);
   assign a_nan  = (&ea) && (fa != '0);
   assign b_nan  = (&eb) && (fb != '0);
   assign a_snan = a_nan && !fa[MAN_W-1];
   assign b_snan = b_nan && !fb[MAN_W-1];
   assign is_mul = (op_ctrl == OP_MUL);
   assign is_div = (op_ctrl == OP_DIV);
   assign sgn    = op_a[FW-1] ^ op_b[FW-1];

   assign in_ready  = (state == S_IDLE) && rst;
   assign out_valid = (state == S_DONE);
   assign accept    = in_valid && in_ready;

`ifdef FP_MULDIV_FLUSH_EN
   logic [TAG_W-1:0] age_diff;
   assign age_diff = rob_out - flush_tag;
   // Squash when the in-flight tag is the flush tag or younger in circular order.
   assign squash   = flush && (state != S_IDLE) && !age_diff[TAG_W-1];
`else
   assign squash   = 1'b0;
`endif

   always_comb begin
      special    = 1'b1;
      spec_f     = QNAN;
      spec_flags = 5'b00000;
      if (!is_mul && !is_div) begin
         spec_flags = 5'b10000;
      end else if (a_nan || b_nan) begin
         spec_flags = {a_snan || b_snan, 4'b0000};
      end else if (is_mul) begin
         if ((a_zero && b_inf) || (a_inf && b_zero)) spec_flags = 5'b10000;
         else if (a_inf || b_inf) spec_f = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         else if (a_zero || b_zero) spec_f = {sgn, {(FW-1){1'b0}}};
         else special = 1'b0;
      end else begin
         if ((a_zero && b_zero) || (a_inf && b_inf)) spec_flags = 5'b10000;
         else if (a_inf) spec_f = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         else if (b_zero) begin
            spec_f     = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            spec_flags = 5'b01000;
         end
         else if (a_zero || b_inf) spec_f = {sgn, {(FW-1){1'b0}}};
         else special = 1'b0;
      end
   end

   // The significand always arrives with its leading one at bit SW-1 or SW-2.
   logic              hi, guard, sticky, rnd_up;
   logic [SW-1:0]     sig_n;
   logic [MAN_W-1:0]  mant;
   logic [MAN_W:0]    mant_r;
   logic signed [EW-1:0] exp_r;

   assign hi     = sig[SW-1];
   assign sig_n  = hi ? sig : (sig << 1);
   assign mant   = sig_n[SW-2 -: MAN_W];
   assign guard  = sig_n[SW-2-MAN_W];
   assign sticky = |sig_n[SW-3-MAN_W:0];
   assign rnd_up = guard && (sticky || mant[0]);
   assign mant_r = {1'b0, mant} + {{MAN_W{1'b0}}, rnd_up};
   assign exp_r  = exp_q + EW'(hi) + EW'(mant_r[MAN_W]);

   always_comb begin
      rnd_f     = {sgn, exp_r[EXP_W-1:0], mant_r[MAN_W-1:0]};
      rnd_flags = {4'b0000, guard || sticky};
      if (exp_r >= EMAX) begin
         rnd_f     = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         rnd_flags = 5'b00101;
      end else if (exp_r[EW-1] || exp_r == '0) begin
         rnd_f     = {sgn, {(FW-1){1'b0}}};
         rnd_flags = 5'b00011;
      end
   end

   always_comb begin
      state_n = state;
      case (state)
         S_IDLE:    if (accept) state_n = S_UNPACK;
         S_UNPACK:  state_n = special ? S_SPECIAL : (is_mul ? S_MUL : S_DIV);
         S_MUL:     state_n = S_ROUND;
         S_DIV:     if (cnt == '0) state_n = S_ROUND;
         S_SPECIAL: state_n = S_DONE;
         S_ROUND:   state_n = S_DONE;
         S_DONE:    if (out_ready) state_n = S_IDLE;
         default:   state_n = S_IDLE;
      endcase
      if (squash) state_n = S_IDLE;
   end

   always_ff @(posedge clk) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_n;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         op_a <= '0; op_b <= '0; op_ctrl <= '0;
         ma <= '0; mb <= '0; rem <= '0; quo <= '0; cnt <= '0;
         sig <= '0; exp_q <= '0;
         f <= '0; flags <= '0; rob_out <= '0; save_out <= '0;
      end else begin
         case (state)
            S_IDLE: if (accept) begin
               op_a <= d; op_b <= e; op_ctrl <= ctrl;
               rob_out <= rob_in; save_out <= save_in;
            end
            S_UNPACK: begin
               if (special) begin
                  f <= spec_f; flags <= spec_flags;
               end else begin
                  ma    <= {1'b1, fa};
                  mb    <= {1'b1, fb};
                  rem   <= {2'b01, fa};
                  quo   <= '0;
                  cnt   <= CW'(DIV_IT);
                  exp_q <= is_mul ? ({2'b00, ea} + {2'b00, eb} - EW'(BIAS))
                                  : ({2'b00, ea} - {2'b00, eb} + EW'(BIAS));
               end
            end
            S_MUL: sig <= SW'(ma) * SW'(mb);
            S_DIV: begin
               if (cnt != '0) begin
                  if (rem >= {1'b0, mb}) begin
                     quo <= {quo[DIV_IT-2:0], 1'b1};
                     rem <= (rem - {1'b0, mb}) << 1;
                  end else begin
                     quo <= {quo[DIV_IT-2:0], 1'b0};
                     rem <= rem << 1;
                  end
                  cnt <= cnt - 1'b1;
               // Quotient below 1.0 is renormalised here so ROUND sees the same layout as MUL.
               end else if (quo[DIV_IT-1]) begin
                  sig <= {1'b0, quo, {(SW-DIV_IT-2){1'b0}}, rem != '0};
               end else begin
                  sig   <= {1'b0, quo[DIV_IT-2:0], 1'b0, {(SW-DIV_IT-2){1'b0}}, rem != '0};
                  exp_q <= exp_q - 1'b1;
               end
            end
            S_ROUND: begin
               f <= rnd_f; flags <= rnd_flags;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_fp_muldiv_unit.sv
// Directed bench for fp_muldiv_unit: latency, results, flags, tags, backpressure, reset, flush.
module tb_fp_muldiv_unit;
   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [3:0]  ctrl;
   logic [31:0] d, e, f;
   logic [4:0]  rob_in, save_in, rob_out, save_out, flags;
`ifdef FP_MULDIV_FLUSH_EN
   logic        flush;
   logic [4:0]  flush_tag;
`endif

   int n_tests = 0;
   int n_fail  = 0;
   logic [46:0] exp_q[$];

   fp_muldiv_unit dut (
      .clk(clk), .rst(rst),
`ifdef FP_MULDIV_FLUSH_EN
      .flush(flush), .flush_tag(flush_tag),
`endif
      .in_valid(in_valid), .in_ready(in_ready), .ctrl(ctrl), .d(d), .e(e),
      .rob_in(rob_in), .save_in(save_in), .out_valid(out_valid), .out_ready(out_ready),
      .f(f), .rob_out(rob_out), .save_out(save_out), .flags(flags)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic run_op(input string name, input logic [3:0] c, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] tag, input bit expect_out,
                         input int exp_lat, input logic [31:0] exp_f, input logic [4:0] exp_fl,
                         input int hold, input int flush_at, input logic [4:0] ftag);
      int lat;
      int nvalid;
      logic [46:0] ent;
      logic [31:0] f_hold;
      @(negedge clk);
      check_eq({name, " in_ready"}, in_ready, 1);
      in_valid = 1'b1; ctrl = c; d = a; e = b; rob_in = tag; save_in = 5'(tag + 5'd1);
      if (expect_out) exp_q.push_back({tag, 5'(tag + 5'd1), exp_fl, exp_f});
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      if (expect_out) begin
         while (out_valid !== 1'b1 && lat < 200) begin
`ifdef FP_MULDIV_FLUSH_EN
            if (lat == flush_at - 1) begin flush = 1'b1; flush_tag = ftag; end
`endif
            @(posedge clk); #1;
`ifdef FP_MULDIV_FLUSH_EN
            flush = 1'b0;
`endif
            lat++;
         end
         check_eq({name, " latency"}, lat, exp_lat);
         if (out_valid === 1'b1 && exp_q.size() > 0) begin
            ent = exp_q.pop_front();
            check_eq({name, " f"}, f, ent[31:0]);
            check_eq({name, " flags"}, flags, ent[36:32]);
            check_eq({name, " save_out"}, save_out, ent[41:37]);
            check_eq({name, " rob_out"}, rob_out, ent[46:42]);
         end
         f_hold = f;
         for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check_eq({name, " hold f"}, f, f_hold);
            check_eq({name, " hold out_valid"}, out_valid, 1);
            check_eq({name, " hold in_ready"}, in_ready, 0);
         end
         @(negedge clk); out_ready = 1'b1;
         @(posedge clk); #1; out_ready = 1'b0;
         check_eq({name, " consumed"}, out_valid, 0);
      end else begin
         nvalid = 0;
         for (int i = 0; i < 60; i++) begin
`ifdef FP_MULDIV_FLUSH_EN
            if (i == flush_at - 1) begin flush = 1'b1; flush_tag = ftag; end
`endif
            @(posedge clk); #1;
`ifdef FP_MULDIV_FLUSH_EN
            flush = 1'b0;
`endif
            if (out_valid) nvalid++;
         end
         check_eq({name, " no result"}, nvalid, 0);
         check_eq({name, " idle after"}, in_ready, 1);
      end
   endtask

   initial begin
      int nvalid;
      rst = 1'b0; in_valid = 1'b0; ctrl = '0; d = '0; e = '0;
      rob_in = '0; save_in = '0; out_ready = 1'b0;
`ifdef FP_MULDIV_FLUSH_EN
      flush = 1'b0; flush_tag = '0;
`endif
      repeat (3) @(posedge clk);
      #1;
      check_eq("reset out_valid", out_valid, 0);
      check_eq("reset in_ready", in_ready, 0);
      check_eq("reset f", f, 0);
      check_eq("reset flags", flags, 0);
      check_eq("reset rob_out", rob_out, 0);
      @(negedge clk); rst = 1'b1;

      run_op("div1",   4'b0011, 32'hc396d200, 32'hc0100000, 5'd3, 1, 29, 32'h43061000, 5'b00000, 0, 0, 0);
      run_op("mul2",   4'b0010, 32'h40ae0000, 32'hbec00000, 5'd4, 1, 3,  32'hc0028000, 5'b00000, 5, 0, 0);
      run_op("divz",   4'b0011, 32'h3f800000, 32'h00000000, 5'd5, 1, 2,  32'h7f800000, 5'b01000, 0, 0, 0);
      run_op("zinf",   4'b0010, 32'h00000000, 32'h7f800000, 5'd6, 1, 2,  32'h7fc00000, 5'b10000, 0, 0, 0);
      run_op("ovf",    4'b0010, 32'h7f000000, 32'h7f000000, 5'd7, 1, 3,  32'h7f800000, 5'b00101, 0, 0, 0);
      run_op("unf",    4'b0010, 32'h00800000, 32'h00800000, 5'd8, 1, 3,  32'h00000000, 5'b00011, 0, 0, 0);
      run_op("mul6",   4'b0010, 32'h40000000, 32'h40400000, 5'd9, 1, 3,  32'h40c00000, 5'b00000, 0, 0, 0);
      run_op("mulnx",  4'b0010, 32'h3f800001, 32'h3f800001, 5'd10, 1, 3, 32'h3f800002, 5'b00001, 0, 0, 0);
      run_op("third",  4'b0011, 32'h3f800000, 32'h40400000, 5'd11, 1, 29, 32'h3eaaaaab, 5'b00001, 0, 0, 0);
      run_op("snan",   4'b0011, 32'h7f800001, 32'h3f800000, 5'd12, 1, 2, 32'h7fc00000, 5'b10000, 0, 0, 0);
      run_op("qnan",   4'b0010, 32'h7fc00000, 32'h3f800000, 5'd13, 1, 2, 32'h7fc00000, 5'b00000, 0, 0, 0);
      run_op("divinf", 4'b0011, 32'h3f800000, 32'hff800000, 5'd14, 1, 2, 32'h80000000, 5'b00000, 0, 0, 0);
      run_op("illegal",4'b0101, 32'h3f800000, 32'h40000000, 5'd15, 1, 2, 32'h7fc00000, 5'b10000, 0, 0, 0);

      // Reset in the middle of a divide.
      @(negedge clk);
      in_valid = 1'b1; ctrl = 4'b0011; d = 32'hc396d200; e = 32'hc0100000; rob_in = 5'd2; save_in = 5'd2;
      @(posedge clk); #1; in_valid = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      check_eq("mid-reset out_valid", out_valid, 0);
      check_eq("mid-reset in_ready", in_ready, 0);
      check_eq("mid-reset f", f, 0);
      @(negedge clk); rst = 1'b1;
      nvalid = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (out_valid) nvalid++;
      end
      check_eq("after reset no result", nvalid, 0);
      run_op("post-rst", 4'b0010, 32'h40ae0000, 32'hbec00000, 5'd1, 1, 3, 32'hc0028000, 5'b00000, 0, 0, 0);

`ifdef FP_MULDIV_FLUSH_EN
      run_op("flush-sq",   4'b0011, 32'hc396d200, 32'hc0100000, 5'd7, 0, 0,  32'h0, 5'b0, 0, 12, 5'd5);
      run_op("flush-keep", 4'b0011, 32'hc396d200, 32'hc0100000, 5'd7, 1, 29, 32'h43061000, 5'b00000, 0, 12, 5'd9);
`endif

      check_eq("scoreboard empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
